vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port video-RAM arbiter between the scan-out path and a pixel writer. It sits between the pattern/scan-out logic, which issues one framebuffer read per displayed framebuffer pixel, and a drawing engine that writes pixels through a valid/ready port. Display reads have absolute priority and fixed latency. Writes are buffered in a small FIFO and drained into idle RAM cycles, optionally only during vertical blanking.

## Interface
- ADDR_W, default 15: framebuffer word address width (160x120 = 19200 words).
- DATA_W, default 12: pixel width, 4 bits each of R, G, B.
- FIFO_DEPTH, default 4: write FIFO entries; power of two, at least 2.

- pixelClk, in, 1: 25 MHz pixel clock; the only clock.
- reset, in, 1: asynchronous, active-high reset.
- disp_req, in, 1: display read strobe, one word per asserted cycle; never stalled.
- disp_addr, in, ADDR_W: read address, sampled with disp_req.
- disp_rvalid, out, 1: read data valid.
- disp_rdata, out, DATA_W: read data.
- wr_valid, in, 1: writer has a pixel.
- wr_ready, out, 1: FIFO can accept a pixel.
- wr_addr, in, ADDR_W: write address.
- wr_data, in, DATA_W: write data.
- blank_only, in, 1: when 1, drain writes only while vblank=1.
- vblank, in, 1: vertical blanking indicator from the timing generator.
- ram_en, out, 1: RAM access enable, registered.
- ram_we, out, 1: RAM write enable, registered.
- ram_addr, out, ADDR_W: RAM address, registered.
- ram_wdata, out, DATA_W: RAM write data, registered.
- ram_rdata, in, DATA_W: synchronous RAM read data, valid the cycle after the access cycle.
- fifo_level, out, clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- busy, out, 1: FIFO non-empty or a RAM access or read return is in flight.

## Operation
- Per-cycle grant decision. Priority order:
  1. DISP when disp_req=1.
  2. DRAIN when the FIFO is non-empty, disp_req=0, and (blank_only=0 or vblank=1).
  3. IDLE otherwise.
- DISP: the next cycle drives ram_en=1, ram_we=0, ram_addr=disp_addr.
- DRAIN: pops the FIFO head. The next cycle drives ram_en=1, ram_we=1, ram_addr/ram_wdata set to the head entry.
- IDLE: the next cycle drives ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their previous values.
- Write FIFO:
  - Push when wr_valid & wr_ready.
  - wr_ready = !full, computed from registered state only, with no combinational path from disp_req or the pop.
  - Full FIFO with a pop in the same cycle: no push that cycle; wr_ready rises the following cycle.
  - Push and pop in the same cycle (not full, not empty): level unchanged, order preserved.
  - FIFO strictly in-order; writes are never merged or dropped.
- Read return pipeline: a 2-stage valid shift tracks DISP grants. disp_rdata is registered from ram_rdata.
- Read/write ordering hazard: a read issued before a buffered write to the same address returns the old data. The writer owns that hazard; the block has no bypass.
- Reset (asynchronous, any time):
  - All outputs go to 0: disp_rvalid, disp_rdata, ram_en, ram_we, ram_addr, ram_wdata, fifo_level, busy.
  - wr_ready goes to 1 while reset is deasserted-sampled empty. During reset it is 0, and it becomes 1 on the first cycle after release.
  - FIFO contents are discarded.
  - In-flight read returns are cancelled; no disp_rvalid follows a pre-reset request.

## Timing
- disp_req in cycle 0 gives:
  - ram_en=1, ram_we=0 in cycle 1;
  - ram_rdata valid in cycle 2;
  - disp_rvalid=1 with disp_rdata in cycle 3.
- Read latency is exactly 3 cycles, fixed, independent of FIFO state.
- Back-to-back disp_req gives back-to-back disp_rvalid at full rate.
- Push in cycle 0 into an empty FIFO: earliest pop is cycle 1, so the earliest RAM write is cycle 2.
- Drain throughput is 1 write per cycle when disp_req=0.
- fifo_level and busy are registered and reflect the state after each edge.
- vblank and blank_only are sampled in the decision cycle only. A pop granted on the last vblank cycle still completes.

## Test plan
- **Read latency:** disp_req=1, disp_addr=0x0010 in cycle 0, RAM model word 0x10 = 0xABC. Expect ram_en=1, ram_we=0, ram_addr=0x0010 in cycle 1; disp_rvalid=1, disp_rdata=0xABC in cycle 3 only.
- **Priority:** 3 writes queued, disp_req held high for 10 cycles. Expect no ram_we during those cycles and fifo_level=3 throughout. After disp_req drops, expect writes in 3 consecutive cycles in push order, then fifo_level=0 and busy=0.
- **Full FIFO:** FIFO_DEPTH=4, wr_valid held, disp_req=1 constantly. Expect wr_ready=0 after 4 accepted pushes. Release disp_req: expect one pop, and wr_ready=1 one cycle later.
- **Blank-only mode:** blank_only=1, vblank=0, 2 writes pushed. Expect no RAM writes. Raise vblank for 1 cycle: expect exactly one RAM write with the oldest entry and fifo_level=1.
- **Reset mid-operation:** 2 reads in flight and 3 FIFO entries, then assert reset asynchronously. Expect all outputs 0 immediately and no disp_rvalid afterwards. After release, expect fifo_level=0 and wr_ready=1 on the first cycle.
- **Random soak:** random disp_req and wr_valid over 10k cycles against a scoreboard. Expect every read at exactly 3-cycle latency, every accepted write in RAM in order, and no lost or duplicated writes.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port video RAM arbiter. Display reads always win and
// return data a fixed three cycles after the request. Pixel writes are queued
// in a small in-order FIFO and drained into cycles the display leaves idle,
// optionally only during vertical blanking.
module vram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          pixelClk,
    input  logic                          reset,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic                          disp_rvalid,
    output logic [DATA_W-1:0]             disp_rdata,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          blank_only,
    input  logic                          vblank,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_DISP  = 2'd1,
        GNT_DRAIN = 2'd2
    } grant_e;

    grant_e grant;
    logic   push;
    logic   pop;

    // FIFO storage: no reset needed, pointers alone define what is valid.
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [LVL_W-1:0]  count_q,     count_d;
    logic              wr_ready_q,  wr_ready_d;
    logic              ram_en_q,    ram_en_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              rv1_q,       rv1_d;
    logic              rv2_q,       rv2_d;
    logic              rvalid_q,    rvalid_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              busy_q,      busy_d;

    // Grant decision, FIFO bookkeeping and next RAM command for this cycle.
    always_comb begin
        grant       = GNT_IDLE;
        push        = wr_valid & wr_ready_q;
        pop         = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        if (disp_req) begin
            grant = GNT_DISP;
        end else if ((count_q != '0) && (!blank_only || vblank)) begin
            grant = GNT_DRAIN;
        end

        case (grant)
            GNT_DISP: begin
                ram_en_d   = 1'b1;
                ram_addr_d = disp_addr;
            end
            GNT_DRAIN: begin
                pop         = 1'b1;
                ram_en_d    = 1'b1;
                ram_we_d    = 1'b1;
                ram_addr_d  = fifo_addr[rd_ptr_q];
                ram_wdata_d = fifo_data[rd_ptr_q];
            end
            default: ;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // Ready comes from the next occupancy so it stays a pure flop output.
        wr_ready_d = (count_d != FULL_LVL);

        // Read return pipeline: access, RAM data, registered output.
        rv1_d    = (grant == GNT_DISP);
        rv2_d    = rv1_q;
        rvalid_d = rv2_q;
        rdata_d  = rv2_q ? ram_rdata : rdata_q;

        busy_d = (count_d != '0) | ram_en_d | rv2_d;
    end

    // Write accepted pixels into the FIFO slot at the write pointer.
    always_ff @(posedge pixelClk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= wr_addr;
            fifo_data[wr_ptr_q] <= wr_data;
        end
    end

    // State registers; reset empties the FIFO and cancels returns in flight.
    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ready_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rv1_q       <= 1'b0;
            rv2_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ready_q  <= wr_ready_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rv1_q       <= rv1_d;
            rv2_q       <= rv2_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign disp_rvalid = rvalid_q;
    assign disp_rdata  = rdata_q;
    assign fifo_level  = count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios plus a random soak. Stimulus
// pushes expected reads/writes into queues; a negedge monitor pops them when
// the DUT presents disp_rvalid or a RAM write. Reads target the lower half of
// the address space (never written), writes the upper half, so expected read
// data is always the initial RAM image.
module tb_vram_arbiter;

    localparam int AW = 15;
    localparam int DW = 12;
    localparam int DEPTH = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          blank_only;
    logic          vblank;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [LW-1:0] fifo_level;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } rd_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    rd_t mon_rd;
    wr_t mon_wr;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .pixelClk   (clk),
        .reset      (rst),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_rvalid(disp_rvalid),
        .disp_rdata (disp_rdata),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .blank_only (blank_only),
        .vblank     (vblank),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Initial framebuffer image; word 0x10 holds 0xABC.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        int v;
        if (a == 15'h0010) return 12'hABC;
        v = int'(a) * 13 + 7 + (int'(a) >> 3);
        return v[DW-1:0];
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = init_val(AW'(i));
    end

    // Synchronous single-port RAM model.
    always @(posedge clk) begin
        if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL rd_missing: no disp_rvalid for addr %0h, required at cycle %0d, now %0d",
                         rd_q[0].addr, rd_q[0].cyc, cyc);
                void'(rd_q.pop_front());
            end
            if (disp_rvalid) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: disp_rvalid=1 data %0h with no read outstanding (cycle %0d)",
                             disp_rdata, cyc);
                end else begin
                    mon_rd = rd_q.pop_front();
                    chk("rd_latency_cycle", cyc, mon_rd.cyc);
                    chk("rd_data", disp_rdata, mon_rd.data);
                    $display("read  addr %0h data %0h cycle %0d", mon_rd.addr, disp_rdata, cyc);
                end
            end
            if (ram_en && ram_we) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: RAM write addr %0h data %0h with none pending (cycle %0d)",
                             ram_addr, ram_wdata, cyc);
                end else begin
                    mon_wr = wr_q.pop_front();
                    chk("wr_addr", ram_addr, mon_wr.addr);
                    chk("wr_data", ram_wdata, mon_wr.data);
                    $display("write addr %0h data %0h cycle %0d", ram_addr, ram_wdata, cyc);
                end
            end
        end
    end

    // Drive one cycle of stimulus and record what the DUT must produce.
    task automatic drive(input logic dreq, input logic [AW-1:0] da,
                         input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        disp_req  = dreq;
        disp_addr = da;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        if (dreq) rd_q.push_back('{da, init_val(da), cyc + 3});
        if (wv && wr_ready) wr_q.push_back('{wa, wd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0);
    endtask

    function automatic logic [AW-1:0] rd_addr();
        return AW'({1'b0, 14'($urandom)} | 15'h1);
    endfunction

    function automatic logic [AW-1:0] wr_addr_r();
        return AW'({1'b1, 14'($urandom)});
    endfunction

    function automatic logic [DW-1:0] wr_data_r();
        return DW'($urandom) | 12'h1;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) idle();
        chk("idle_busy", busy, 0);
        chk("idle_level", fifo_level, 0);
        repeat (3) idle();
    endtask

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        disp_req = 0; disp_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
        blank_only = 0; vblank = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_en", ram_en, 0);
        chk("rst_rvalid", disp_rvalid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        #5 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_wr_ready", wr_ready, 1);
        chk("post_rst_level", fifo_level, 0);

        // Read latency.
        drive(1'b1, 15'h0010, 1'b0, '0, '0);
        chk("lat_ram_en", ram_en, 1);
        chk("lat_ram_we", ram_we, 0);
        chk("lat_ram_addr", ram_addr, 15'h0010);
        repeat (5) idle();

        // Priority: three queued writes held off by continuous reads.
        for (int i = 0; i < 3; i++) drive(1'b1, rd_addr(), 1'b1, wr_addr_r(), wr_data_r());
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rd_addr(), 1'b0, '0, '0);
            chk("prio_level", fifo_level, 3);
            chk("prio_no_we", ram_we, 0);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("prio_drain_we", ram_we, 1);
            chk("prio_drain_level", fifo_level, 32'(2 - i));
        end
        wait_idle();

        // Full FIFO with reads holding off the drain.
        for (int i = 0; i < 6; i++) drive(1'b1, rd_addr(), 1'b1, wr_addr_r(), wr_data_r());
        chk("full_wr_ready", wr_ready, 0);
        chk("full_level", fifo_level, DEPTH);
        drive(1'b0, '0, 1'b1, wr_addr_r(), wr_data_r());
        chk("full_pop_level", fifo_level, DEPTH - 1);
        chk("full_pop_we", ram_we, 1);
        chk("full_ready_rise", wr_ready, 1);
        wait_idle();

        // Blank-only drain.
        blank_only = 1'b1;
        vblank = 1'b0;
        for (int i = 0; i < 2; i++) drive(1'b0, '0, 1'b1, wr_addr_r(), wr_data_r());
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("blank_no_we", ram_we, 0);
            chk("blank_level", fifo_level, 2);
        end
        vblank = 1'b1;
        idle();
        vblank = 1'b0;
        chk("blank_one_we", ram_we, 1);
        chk("blank_one_level", fifo_level, 1);
        idle();
        chk("blank_after_we", ram_we, 0);
        chk("blank_after_level", fifo_level, 1);
        blank_only = 1'b0;
        wait_idle();

        // Asynchronous reset with reads in flight and a loaded FIFO.
        for (int i = 0; i < 3; i++) drive(1'b1, rd_addr(), 1'b1, wr_addr_r(), wr_data_r());
        disp_req = 1'b0;
        wr_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_ram_en", ram_en, 0);
        chk("arst_ram_we", ram_we, 0);
        chk("arst_ram_addr", ram_addr, 0);
        chk("arst_ram_wdata", ram_wdata, 0);
        chk("arst_rvalid", disp_rvalid, 0);
        chk("arst_rdata", disp_rdata, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_busy", busy, 0);
        chk("arst_wr_ready", wr_ready, 0);
        rd_q.delete();
        wr_q.delete();
        repeat (2) @(posedge clk);
        #5 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_rel_level", fifo_level, 0);
        chk("arst_rel_wr_ready", wr_ready, 1);
        repeat (6) idle();

        // Random soak.
        for (int i = 0; i < 10000; i++) begin
            if (i % 200 == 0) blank_only = ($urandom_range(0, 4) == 0);
            vblank = ($urandom_range(0, 9) < 3);
            drive($urandom_range(0, 99) < 45, rd_addr(),
                  $urandom_range(0, 99) < 60, wr_addr_r(), wr_data_r());
        end
        blank_only = 1'b0;
        vblank = 1'b0;
        wait_idle();
        repeat (4) idle();
        chk("soak_reads_left", rd_q.size(), 0);
        chk("soak_writes_left", wr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
